// File: rtl/grid_mem_ctrl.sv
// grid_mem_ctrl: bus master for the 2-bit-per-cell battleship grid memory.
// Turns cell commands into read, read-modify-write and clear bus cycles.
module grid_mem_ctrl #(
    parameter int GRID_SIZE  = 10,
    parameter int SHIP_CELLS = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_row,
    input  logic [3:0] cmd_col,
    output logic       rsp_valid,
    output logic [1:0] rsp_code,
    output logic [1:0] rsp_cell,
    output logic [6:0] hit_count,
    output logic       all_sunk,
    output logic       mem_oe,
    output logic       mem_we,
    output logic [6:0] mem_addr,
    inout  wire  [1:0] mem_data
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_FIRE  = 2'b01;
    localparam logic [1:0] OP_PLACE = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [1:0] CELL_WATER = 2'b00;
    localparam logic [1:0] CELL_SHIP  = 2'b01;
    localparam logic [1:0] CELL_MISS  = 2'b10;
    localparam logic [1:0] CELL_HIT   = 2'b11;

    localparam logic [1:0] RC_OK  = 2'b00;
    localparam logic [1:0] RC_HIT = 2'b01;
    localparam logic [1:0] RC_REP = 2'b10;
    localparam logic [1:0] RC_ERR = 2'b11;

    localparam logic [3:0] GS4      = 4'(GRID_SIZE);
    localparam logic [6:0] GS7      = 7'(GRID_SIZE);
    localparam logic [6:0] LAST     = 7'(GRID_SIZE * GRID_SIZE - 1);
    localparam logic [6:0] SUNK_CNT = 7'(SHIP_CELLS);
    localparam logic [6:0] HIT_MAX  = 7'h7f;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        CLR,
        RESP
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [1:0] op_q;
    logic [1:0] cell_q;
    logic [6:0] addr_q;
    logic [6:0] clr_q;
    logic [6:0] cmd_addr;
    logic       accept;
    logic       bad;
    logic       clr_last;
    logic       wr_en;
    logic       hit;
    logic [1:0] wr_val;
    logic [1:0] code;
    logic [1:0] wdata;

    assign cmd_ready = (state_q == IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign bad       = (cmd_row >= GS4) || (cmd_col >= GS4);
    assign cmd_addr  = 7'(cmd_row) * GS7 + 7'(cmd_col);
    assign clr_last  = (clr_q == LAST);
    assign all_sunk  = (hit_count == SUNK_CNT);

    // Modify decision made from the cell value captured in READ.
    always_comb begin
        wr_en  = 1'b0;
        wr_val = CELL_WATER;
        code   = RC_OK;
        hit    = 1'b0;
        unique case (op_q)
            OP_FIRE: begin
                unique case (cell_q)
                    CELL_WATER: begin
                        wr_en  = 1'b1;
                        wr_val = CELL_MISS;
                    end
                    CELL_SHIP: begin
                        wr_en  = 1'b1;
                        wr_val = CELL_HIT;
                        code   = RC_HIT;
                        hit    = 1'b1;
                    end
                    default: code = RC_REP;
                endcase
            end
            OP_PLACE: begin
                if (cell_q == CELL_WATER) begin
                    wr_en  = 1'b1;
                    wr_val = CELL_SHIP;
                end else begin
                    code = RC_REP;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bad)                   state_d = RESP;
                    else if (cmd_op == OP_CLEAR) state_d = CLR;
                    else                       state_d = READ;
                end
            end
            READ:    state_d = WRITE;
            WRITE:   state_d = RESP;
            CLR:     if (clr_last) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= OP_READ;
            addr_q    <= '0;
            cell_q    <= CELL_WATER;
            clr_q     <= '0;
            rsp_code  <= RC_OK;
            rsp_cell  <= CELL_WATER;
            hit_count <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= cmd_op;
                addr_q <= cmd_addr;
                clr_q  <= '0;
            end
            if (accept && bad) begin
                rsp_code <= RC_ERR;
                rsp_cell <= CELL_WATER;
            end
            if (accept && !bad && cmd_op == OP_CLEAR)
                hit_count <= '0;
            if (state_q == READ)
                cell_q <= mem_data;
            if (state_q == WRITE) begin
                rsp_code <= code;
                rsp_cell <= cell_q;
                if (hit && hit_count != HIT_MAX)
                    hit_count <= hit_count + 7'd1;
            end
            if (state_q == CLR) begin
                clr_q <= clr_q + 7'd1;
                if (clr_last) begin
                    rsp_code <= RC_OK;
                    rsp_cell <= CELL_WATER;
                end
            end
        end
    end

    // Bus strobes are gated by rst so reset takes effect in the same cycle.
    assign mem_oe    = (state_q == READ) && !rst;
    assign mem_we    = ((state_q == WRITE && wr_en) || state_q == CLR) && !rst;
    assign rsp_valid = (state_q == RESP) && !rst;
    assign wdata     = (state_q == CLR) ? CELL_WATER : wr_val;
    assign mem_data  = mem_we ? wdata : 2'bzz;

    always_comb begin
        mem_addr = '0;
        if (!rst) begin
            if (state_q == CLR)
                mem_addr = clr_q;
            else if (state_q == READ || state_q == WRITE)
                mem_addr = addr_q;
        end
    end

endmodule

// File: doc/grid_mem_ctrl.md
Name: grid_mem_ctrl

Overview:
- Bus master for the 10x10 two-bit-per-cell battleship grid memory.
- Accepts cell-level game commands over a valid/ready interface: read, fire, place ship, and clear grid.
- Turns each command into oe/we/addr/data cycles on the shared tri-state bus, including read-modify-write for fire and place.
- Tracks hits and flags when every ship cell is sunk. It sits between the game FSM and the grid memory.

Parameters:
- GRID_SIZE, 10, cells per row/column; address = row*GRID_SIZE + col.
- SHIP_CELLS, 17, total ship cells; all_sunk asserts when hit_count equals this.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  high only in IDLE and not in reset; a command is accepted when cmd_valid and cmd_ready are both high at a clock edge.
- cmd_op  input  2  command: 00 READ, 01 FIRE, 10 PLACE, 11 CLEAR.
- cmd_row  input  4  row index.
- cmd_col  input  4  column index.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_code  output  2  result: 00 OK/MISS, 01 HIT, 10 REPEAT/OCCUPIED, 11 ERR.
- rsp_cell  output  2  cell value read before modification (00 for CLEAR and ERR).
- hit_count  output  7  number of successful hits since reset or CLEAR.
- all_sunk  output  1  high when hit_count == SHIP_CELLS.
- mem_oe  output  1  memory output enable.
- mem_we  output  1  memory write enable; the memory captures data on the rising clk edge.
- mem_addr  output  7  cell address.
- mem_data  inout  2  shared data bus; driven by this block only while mem_we=1, otherwise Z.

Behaviour:
- Cell encoding: 00 water, 01 ship, 10 miss, 11 hit.
- Memory read is combinational while oe=1 and we=0. The controller samples mem_data at the edge ending its READ cycle.
- States and transitions:
  - IDLE: on accept, latch op/row/col. If row or col >= GRID_SIZE, go to RESP with ERR (no bus activity). Otherwise CLEAR goes to CLR; all other ops go to READ.
  - READ: one cycle with mem_oe=1, mem_we=0, mem_addr=row*GRID_SIZE+col. Latch the cell value.
  - WRITE: one cycle with mem_oe=0; mem_we=1 only when a write is required. Write rules:
    - FIRE on 00: write 10, code 00.
    - FIRE on 01: write 11, code 01, hit_count+1.
    - FIRE on 10/11: no write, code 10.
    - PLACE on 00: write 01, code 00.
    - PLACE on 01/10/11: no write, code 10.
    - READ: no write, code 00.
  - CLR: writes 00 at addresses 0..GRID_SIZE^2-1, one per cycle (mem_we=1, mem_data=00). hit_count clears to 0 at entry.
  - RESP: rsp_valid=1 for exactly one cycle, then IDLE.
- mem_oe and mem_we are never both high. Bus direction changes only at state boundaries.
- Latency, with acceptance at edge N:
  - READ/FIRE/PLACE: rsp_valid in cycle N+3; cmd_ready high again at N+4.
  - ERR: rsp_valid in N+1.
  - CLEAR (GRID_SIZE=10): writes occupy cycles N+1..N+100; rsp_valid in N+101.
- cmd_valid is ignored while not in IDLE; no queuing.
- rsp_code and rsp_cell hold their values until the next response.
- hit_count saturates at 127 and never wraps. all_sunk is combinational from hit_count.
- Reset:
  - Any state returns to IDLE.
  - rsp_valid=0, rsp_code=00, rsp_cell=00, hit_count=0, mem_oe=0, mem_we=0, mem_addr=0, mem_data=Z.
  - cmd_ready=0 while rst is high.
  - Reset mid-CLEAR or mid-RMW abandons the operation with no response; partially cleared cells stay as written.
  - Memory contents are not reset; software issues CLEAR.

Test Plan:
- rst high 2 cycles, then CLEAR -> 100 consecutive we cycles, addr 0..99, data 00. rsp_valid at N+101 with code 00. hit_count=0.
- PLACE (2,3) on cleared grid -> READ addr 23, WRITE 01 at N+2, rsp code 00 cell 00. Repeat PLACE (2,3) -> no we pulse, code 10 cell 01.
- FIRE (2,3) after placement -> writes 11, code 01, hit_count=1. FIRE (2,3) again -> no write, code 10 cell 11, hit_count stays 1. FIRE (0,0) -> writes 10, code 00.
- FIRE row=10 col=0 -> no oe/we activity, rsp_valid at N+1, code 11.
- Place 17 ship cells, fire all 17 -> all_sunk rises on the cycle after the 17th hit's WRITE edge. A following CLEAR drops it to 0.
- Assert rst at cycle N+40 of a CLEAR -> no rsp_valid; cmd_ready=0 during rst and 1 the cycle after. READ addr 50 -> code 00, cell unchanged from before the CLEAR; READ addr 30 -> cell 00.
